lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter MEM_WAIT, default 0, range 0..15: extra cycles mem_ce is held before read data is captured.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  EX stage presents a load/store.
REQ-005 req_ready  output  1  LSU can accept a request.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_addr  input  64  byte address.
REQ-008 req_wdata  input  64  store data, LSB-aligned.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 dword.
REQ-010 req_unsigned  input  1  zero-extend load (LBU/LHU/LWU).
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  WB stage accepts result.
REQ-013 rsp_rdata  output  64  extended load data; 0 for stores.
REQ-014 rsp_misalign  output  1  access was misaligned and suppressed.
REQ-015 mem_addr  output  64  8-byte-aligned address to memory model.
REQ-016 mem_ce  output  1  memory chip enable.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_wdata  output  64  lane-shifted store data.
REQ-019 mem_wmask  output  8  byte-lane write mask.
REQ-020 mem_rdata  input  64  combinational read data from memory model.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-022 IDLE: on req_valid, latch all req_* fields; go ACCESS (or RESP if REQ-029 suppresses).
REQ-023 ACCESS lasts exactly MEM_WAIT+1 cycles, tracked by a 4-bit down-counter; mem_ce=1 throughout, 0 in every other state.
REQ-024 mem_addr = latched addr & ~7; mem_we = latched we during ACCESS, else 0.
REQ-025 Store: mem_wmask = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0], truncated to 8 bits; mem_wdata = wdata << (8*addr[2:0]); mem_wmask=0 for loads and outside ACCESS.
REQ-026 Load: on last ACCESS cycle capture (mem_rdata >> 8*addr[2:0]), truncate to size, sign-extend unless req_unsigned or size=11.
REQ-027 RESP: rsp_valid=1, outputs stable until rsp_ready=1; that cycle returns to IDLE; no new request accepted in same cycle.
REQ-028 Latency: request accepted at edge N -> rsp_valid high from cycle N+2+MEM_WAIT with rsp_ready held high; throughput one op per MEM_WAIT+3 cycles.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined: addr not aligned to size -> no memory access (mem_ce stays 0), go IDLE->RESP directly, rsp_misalign=1, rsp_rdata=0.
REQ-030 Without LSU_MISALIGN_TRAP_EN: misaligned access proceeds per REQ-025/026 with bytes past the 8-byte boundary dropped; rsp_misalign tied 0.

Reset
REQ-031 rst_n low asynchronously forces IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_misalign=0, mem_ce=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset mid-ACCESS aborts the access; no response is produced for the aborted request.

Structure
REQ-033 Shared package/defines header holds size encodings, FSM state encodings and size-to-mask constants.
REQ-034 One combinational sub-module lsu_align computes wmask, shifted wdata and extended rdata; FSM and counter stay in lsu.

Verification
REQ-035 Store byte: addr 0x80000005, wdata 0xAB, size 00, MEM_WAIT 0 -> one ACCESS cycle, mem_addr 0x80000000, wmask 0x20, wdata 0x0000AB0000000000.
REQ-036 Signed load half: mem_rdata 0x0000_8001_0000_0000, addr 0x...4 -> rsp_rdata 0xFFFFFFFFFFFF8001; with req_unsigned -> 0x0000000000008001.
REQ-037 MEM_WAIT 3, load dword -> mem_ce high exactly 4 cycles, rsp_valid at N+5.
REQ-038 Backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0, no mem_ce pulse.
REQ-039 Misaligned word load at addr 0x...2 with LSU_MISALIGN_TRAP_EN -> mem_ce never asserted, rsp_misalign 1, rsp_rdata 0; without macro -> access performed, rsp_misalign 0.
REQ-040 rst_n asserted during ACCESS -> all outputs zero immediately, FSM IDLE, no rsp_valid after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, lane masks.
// Used by lsu, lsu_align and lsu_if users via import lsu_pkg::*.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // Request fields captured when the LSU accepts an operation.
    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        size_e       size;
        logic        uns;
    } req_t;

    function automatic logic [7:0] size_mask(size_e size);
        case (size)
            SIZE_B:  return MASK_B;
            SIZE_H:  return MASK_H;
            SIZE_W:  return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    function automatic logic is_misaligned(size_e size, logic [2:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU request, response and memory-side signals.
// master = pipeline (EX/WB) plus memory model, slave = the LSU itself.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_misalign;

    logic [63:0] mem_addr;
    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign,
        input  mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign,
        output mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: store mask/data shift into the 8-byte word,
// load data shift down, truncate to size and sign/zero extend.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [2:0]  offset,
    input  logic        uns,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wmask,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [63:0] rdata_sh;

    // Bytes pushed past the 8-byte boundary simply fall off the top.
    assign wmask    = size_mask(size) << offset;
    assign wdata_sh = wdata << {offset, 3'b000};
    assign rdata_sh = rdata >> {offset, 3'b000};

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        rdata_ext = rdata_sh;
        case (size)
            SIZE_B: rdata_ext = uns ? {56'd0, rdata_sh[7:0]}
                                    : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
            SIZE_H: rdata_ext = uns ? {48'd0, rdata_sh[15:0]}
                                    : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            SIZE_W: rdata_ext = uns ? {32'd0, rdata_sh[31:0]}
                                    : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE -> ACCESS (MEM_WAIT+1 cycles) -> RESP handshake FSM.
// Define LSU_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q;
    req_t        req_q;
    logic [63:0] rdata_q;
    logic        accept;
    logic        access_last;
    logic        trap;
    logic [7:0]  wmask;
    logic [63:0] wdata_sh;
    logic [63:0] rdata_ext;

    assign accept      = (state_q == ST_IDLE) && bus.req_valid;
    assign access_last = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap = is_misaligned(size_e'(bus.req_size), bus.req_addr[2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (accept)
            misalign_q <= trap;
    end

    assign bus.rsp_misalign = misalign_q;
`else
    assign trap             = 1'b0;
    assign bus.rsp_misalign = 1'b0;
`endif

    lsu_align u_align (
        .size      (req_q.size),
        .offset    (req_q.addr[2:0]),
        .uns       (req_q.uns),
        .wdata     (req_q.wdata),
        .rdata     (bus.mem_rdata),
        .wmask     (wmask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = trap ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_ce    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wmask = 8'h00;
        bus.mem_wdata = 64'd0;
        case (state_q)
            ST_IDLE:   bus.req_ready = 1'b1;
            ST_ACCESS: begin
                bus.mem_ce = 1'b1;
                bus.mem_we = req_q.we;
                if (req_q.we) begin
                    bus.mem_wmask = wmask;
                    bus.mem_wdata = wdata_sh;
                end
            end
            ST_RESP:   bus.rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    assign bus.mem_addr  = {req_q.addr[63:3], 3'b000};
    assign bus.rsp_rdata = rdata_q;

    // NOTE: these are a handful of control/data flops, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
        end else begin
            if (accept) begin
                req_q   <= '{we:    bus.req_we,
                             addr:  bus.req_addr,
                             wdata: bus.req_wdata,
                             size:  size_e'(bus.req_size),
                             uns:   bus.req_unsigned};
                cnt_q   <= 4'(MEM_WAIT);
                rdata_q <= 64'd0;
            end else if (state_q == ST_ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // mem_rdata is combinational, so sample it in the final ACCESS cycle.
            if (access_last)
                rdata_q <= req_q.we ? 64'd0 : rdata_ext;
        end
    end

endmodule
